sdram_req_queue: RTL and testbench
==================================

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

Interface
REQ-001 Parameter HADDR_WIDTH, default 25: host byte-address width (bank+row+col).
REQ-002 Parameter DEPTH, default 4: request FIFO entries; power of two, >=2.
REQ-003 Reset rst_n, synchronous, active-low; clock clk.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  FIFO can accept; transfer when req_valid && req_ready.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  HADDR_WIDTH  request address.
REQ-010 req_wdata  input  8  write byte; ignored for reads.
REQ-011 rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-012 rsp_data  output  8  read byte.
REQ-013 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 ctl_wr_addr, ctl_rd_addr  output  HADDR_WIDTH each  addresses to controller.
REQ-015 ctl_wr_data  output  8  write byte to controller.
REQ-016 ctl_wr_enable, ctl_rd_enable  output  1 each  request strobes to controller.
REQ-017 ctl_ack  input  1  controller one-cycle acceptance pulse.
REQ-018 ctl_rd_ready  input  1  controller one-cycle read-data-valid pulse.
REQ-019 ctl_rd_data  input  8  controller read byte, valid with ctl_rd_ready.

Function
REQ-020 FIFO SHALL store {we, addr, wdata} entries in order; req_ready = (level < DEPTH), combinational from registered level.
REQ-021 Push on req_valid && req_ready; pop only when the issuer loads an entry; simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-022 Issuer FSM states: S_IDLE, S_ISSUE, S_WAIT_RD.
REQ-023 S_IDLE, FIFO non-empty: pop head, drive ctl_*_addr (and ctl_wr_data) from it, assert ctl_wr_enable if we=1 else ctl_rd_enable (exactly one), go S_ISSUE; FIFO empty: stay, both enables 0.
REQ-024 S_ISSUE: hold enable, address and data stable until ctl_ack sampled 1; on that edge clear enable; write -> S_IDLE, read -> S_WAIT_RD.
REQ-025 No ack timeout; S_ISSUE SHALL wait indefinitely (refresh may delay ack).
REQ-026 S_WAIT_RD: on ctl_rd_ready=1 register ctl_rd_data into rsp_data, pulse rsp_valid next cycle for exactly one cycle, go S_IDLE.
REQ-027 At most one read outstanding; responses therefore SHALL return in request order.
REQ-028 Writes SHALL NOT wait for completion; next entry may issue in the cycle after ack, giving minimum 2-cycle write issue spacing.
REQ-029 ctl_ack or ctl_rd_ready arriving in an unexpected state SHALL be ignored.
REQ-030 ctl_wr_enable and ctl_rd_enable SHALL never be 1 simultaneously.
REQ-031 rsp_data SHALL hold its last value between pulses.

Reset
REQ-032 rst_n=0 at an edge: FIFO pointers and level 0, FSM S_IDLE, ctl_wr_enable=ctl_rd_enable=0, rsp_valid=0, rsp_data=0, addresses/wdata 0; req_ready=1 the following cycle.
REQ-033 Reset mid-transaction SHALL discard queued and in-flight requests; no rsp_valid SHALL follow for a read issued before reset.

Verification
REQ-034 Single write addr=0x0000123 data=0xA5 -> ctl_wr_enable=1 one cycle after push, held until ack, cleared next edge; no rsp_valid.
REQ-035 Write 0x5A to 0x1000, then read 0x1000 with controller model -> one rsp_valid pulse, rsp_data=0x5A, read issued only after write ack.
REQ-036 Push 4 requests with ack stalled 20 cycles -> level=4, req_ready=0, 5th request not accepted; after acks level drains to 0.
REQ-037 Three reads 0x10, 0x20, 0x30 back-to-back, model returns 0x11, 0x22, 0x33 -> rsp_data sequence 0x11, 0x22, 0x33, never more than one ctl_rd_enable before matching ctl_rd_ready.
REQ-038 Full FIFO with simultaneous push and issuer pop -> level stays 4 minus 0 net only when not full; at level=3 push+pop keeps level=3.
REQ-039 Assert rst_n=0 while in S_WAIT_RD, then pulse ctl_rd_ready -> no rsp_valid, level=0, enables 0.

Source files
------------

// File: rtl/sdram_req_queue.sv
// -----------------------------------------------------------------------------
// sdram_req_queue
//
// Host-side request queue in front of a single-port SDRAM controller. Host
// requests {we, addr, wdata} are buffered in a small in-order FIFO. An issuer
// FSM pops one entry at a time and presents it to the controller as a
// registered strobe plus address/data. The strobe is held until the controller
// acknowledges it. Writes retire on acknowledge. Reads then wait for the
// controller's read-data pulse, which is returned to the host as a one-cycle
// rsp_valid pulse. Only one read is ever outstanding, so responses come back
// in request order.
//
// Parameters
//   HADDR_WIDTH  host byte-address width (bank+row+col)
//   DEPTH        FIFO entries, power of two, >= 2
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          synchronous active-low reset
//   req_valid      host request present
//   req_ready      FIFO can accept (level < DEPTH)
//   req_we         1 = write, 0 = read
//   req_addr       request address
//   req_wdata      write byte (ignored for reads)
//   rsp_valid      one-cycle pulse, rsp_data carries read byte
//   rsp_data       last read byte, held between pulses
//   level          current FIFO occupancy
//   ctl_wr_addr    write address to controller
//   ctl_rd_addr    read address to controller
//   ctl_wr_data    write byte to controller
//   ctl_wr_enable  write strobe, held until ctl_ack
//   ctl_rd_enable  read strobe, held until ctl_ack
//   ctl_ack        controller one-cycle acceptance pulse
//   ctl_rd_ready   controller one-cycle read-data-valid pulse
//   ctl_rd_data    controller read byte, valid with ctl_rd_ready
// -----------------------------------------------------------------------------
module sdram_req_queue #(
    parameter int HADDR_WIDTH = 25,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [HADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [HADDR_WIDTH-1:0]   ctl_wr_addr,
    output logic [HADDR_WIDTH-1:0]   ctl_rd_addr,
    output logic [7:0]               ctl_wr_data,
    output logic                     ctl_wr_enable,
    output logic                     ctl_rd_enable,
    input  logic                     ctl_ack,
    input  logic                     ctl_rd_ready,
    input  logic [7:0]               ctl_rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef struct packed {
        logic                   we;
        logic [HADDR_WIDTH-1:0] addr;
        logic [7:0]             wdata;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD
    } state_t;

    // -------------------------------------------------------------------------
    // Request FIFO
    // -------------------------------------------------------------------------
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;

    logic   push;
    logic   pop;
    entry_t head;

    state_t state_q, state_d;

    assign req_ready = (level_q < DEPTH_L);
    assign push      = req_valid && req_ready;
    // The issuer is the only consumer: it takes the head whenever it is idle.
    assign pop       = (state_q == S_IDLE) && (level_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign level     = level_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;   // idle, or push+pop cancel out
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of block evaluation order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level already mark
    // every entry invalid, and leaving the array out of reset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        end
    end

    // -------------------------------------------------------------------------
    // Issuer FSM
    // -------------------------------------------------------------------------
    logic                   wr_en_q,   wr_en_d;
    logic                   rd_en_q,   rd_en_d;
    logic [HADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [HADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   rsp_vld_q, rsp_vld_d;
    logic [7:0]             rsp_dat_q, rsp_dat_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. Acks outside S_ISSUE and read-data pulses outside
    // S_WAIT_RD simply do not appear in the transition conditions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // No timeout: a refresh can hold off the ack arbitrarily long.
                if (ctl_ack) state_d = wr_en_q ? S_IDLE : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (ctl_rd_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered controller/host outputs.
    // Strobes are loaded on the idle->issue edge, so they are driven straight
    // from flops and stay stable for the whole S_ISSUE period.
    always_comb begin
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        rsp_vld_d = 1'b0;
        rsp_dat_d = rsp_dat_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head.we) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = head.addr;
                        wr_data_d = head.wdata;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = head.addr;
                    end
                end
            end
            S_ISSUE: begin
                if (ctl_ack) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                end
            end
            S_WAIT_RD: begin
                if (ctl_rd_ready) begin
                    rsp_vld_d = 1'b1;
                    rsp_dat_d = ctl_rd_data;
                end
            end
            default: begin
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign ctl_wr_enable = wr_en_q;
    assign ctl_rd_enable = rd_en_q;
    assign ctl_wr_addr   = wr_addr_q;
    assign ctl_rd_addr   = rd_addr_q;
    assign ctl_wr_data   = wr_data_q;
    assign rsp_valid     = rsp_vld_q;
    assign rsp_data      = rsp_dat_q;

endmodule

// File: tb/tb_sdram_req_queue.sv
// -----------------------------------------------------------------------------
// tb_sdram_req_queue
//
// Directed bench for sdram_req_queue. A small SDRAM controller model answers
// strobes after a programmable ack stall and returns read data after a
// programmable latency. A monitor logs responses and watches strobe exclusion
// and the single-outstanding-read rule. Inputs and checks happen 2 time units
// after the falling edge; the controller model drives at the falling edge and
// the monitor samples 1 unit after it.
// -----------------------------------------------------------------------------
module tb_sdram_req_queue;

    localparam int HAW   = 25;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [HAW-1:0]  req_addr;
    logic [7:0]      req_wdata;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic [2:0]      level;
    logic [HAW-1:0]  ctl_wr_addr;
    logic [HAW-1:0]  ctl_rd_addr;
    logic [7:0]      ctl_wr_data;
    logic            ctl_wr_enable;
    logic            ctl_rd_enable;
    logic            ctl_ack      = 1'b0;
    logic            ctl_rd_ready = 1'b0;
    logic [7:0]      ctl_rd_data  = 8'h00;

    always #5 clk = ~clk;

    sdram_req_queue #(.HADDR_WIDTH(HAW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .level         (level),
        .ctl_wr_addr   (ctl_wr_addr),
        .ctl_rd_addr   (ctl_rd_addr),
        .ctl_wr_data   (ctl_wr_data),
        .ctl_wr_enable (ctl_wr_enable),
        .ctl_rd_enable (ctl_rd_enable),
        .ctl_ack       (ctl_ack),
        .ctl_rd_ready  (ctl_rd_ready),
        .ctl_rd_data   (ctl_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Controller model knobs (written by the stimulus only).
    int ack_stall = 0;
    int rd_lat    = 2;
    bit force_ack = 1'b0;
    bit force_rd  = 1'b0;

    // Controller model state (written by the model only).
    logic [7:0] mdl_mem [0:8191];
    bit         mdl_wr  [0:8191];
    int         stall_cnt    = 0;
    bit         ack_given    = 1'b0;
    int         rd_pend_cnt  = 0;
    logic [7:0] rd_pend_data = 8'h00;

    // Unwritten locations read back as {a[7:4], a[7:4]}: 0x10 -> 0x11 etc.
    always @(negedge clk) begin
        logic [12:0] a;
        ctl_ack      = 1'b0;
        ctl_rd_ready = 1'b0;
        if (!rst_n) begin
            ack_given   = 1'b0;
            stall_cnt   = 0;
            rd_pend_cnt = 0;
        end else begin
            if (rd_pend_cnt > 0) begin
                rd_pend_cnt--;
                if (rd_pend_cnt == 0) begin
                    ctl_rd_ready = 1'b1;
                    ctl_rd_data  = rd_pend_data;
                end
            end
            if (!ctl_wr_enable && !ctl_rd_enable) begin
                ack_given = 1'b0;
                stall_cnt = 0;
            end else if (!ack_given) begin
                if (stall_cnt < ack_stall) begin
                    stall_cnt++;
                end else begin
                    ctl_ack   = 1'b1;
                    ack_given = 1'b1;
                    if (ctl_wr_enable) begin
                        a = ctl_wr_addr[12:0];
                        mdl_mem[a] = ctl_wr_data;
                        mdl_wr[a]  = 1'b1;
                    end else begin
                        a = ctl_rd_addr[12:0];
                        rd_pend_data = mdl_wr[a] ? mdl_mem[a] : {a[7:4], a[7:4]};
                        rd_pend_cnt  = rd_lat;
                    end
                end
            end
        end
        if (force_ack) ctl_ack = 1'b1;
        if (force_rd) begin
            ctl_rd_ready = 1'b1;
            ctl_rd_data  = 8'hEE;
        end
    end

    // Monitor (written by the monitor only).
    int         cyc          = 0;
    int         rsp_cnt      = 0;
    logic [7:0] rsp_log [0:63];
    int         both_err     = 0;
    int         order_err    = 0;
    int         rd_out       = 0;
    int         rd_issue_cyc = 0;
    int         wr_ack_cyc   = 0;
    int         wr_issue_cnt = 0;
    bit         prev_rd_en   = 1'b0;
    bit         prev_wr_en   = 1'b0;

    always @(negedge clk) begin
        #1;
        cyc++;
        if (rsp_valid === 1'b1) begin
            if (rsp_cnt < 64) rsp_log[rsp_cnt] = rsp_data;
            rsp_cnt++;
        end
        if (ctl_wr_enable === 1'b1 && ctl_rd_enable === 1'b1) both_err++;
        if (!rst_n) begin
            rd_out = 0;
        end else begin
            if (ctl_rd_enable && !prev_rd_en) begin
                if (rd_out != 0) order_err++;
                rd_out++;
                rd_issue_cyc = cyc;
            end
            if (ctl_wr_enable && !prev_wr_en) wr_issue_cnt++;
            if (ctl_ack && ctl_wr_enable) wr_ack_cyc = cyc;
            if (ctl_rd_ready && rd_out > 0) rd_out--;
        end
        prev_rd_en = ctl_rd_enable;
        prev_wr_en = ctl_wr_enable;
    end

    // -------------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [HAW-1:0] a, input logic [7:0] d);
        int budget = 200;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("push_ready_timeout", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int budget = 200;
        do begin
            step();
            budget--;
        end while (ctl_ack !== 1'b1 && budget > 0);
        if (ctl_ack !== 1'b1) check(tag, ctl_ack, 1);
    endtask

    task automatic wait_rsp(input string tag, input int target);
        int budget = 300;
        while (rsp_cnt < target && budget > 0) begin
            step();
            budget--;
        end
        if (rsp_cnt < target) check(tag, rsp_cnt, target);
    endtask

    // -------------------------------------------------------------------------
    initial begin
        int base;
        int budget;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (3) step();
        check("rst_level",   level,         0);
        check("rst_wr_en",   ctl_wr_enable, 0);
        check("rst_rd_en",   ctl_rd_enable, 0);
        check("rst_rsp_vld", rsp_valid,     0);
        check("rst_rsp_dat", rsp_data,      0);
        check("rst_wr_addr", ctl_wr_addr,   0);
        check("rst_rd_addr", ctl_rd_addr,   0);
        check("rst_wr_data", ctl_wr_data,   0);
        rst_n = 1'b1;
        step();
        check("rst_ready", req_ready, 1);

        // Single write, ack stalled 3 cycles
        ack_stall = 3;
        base = rsp_cnt;
        push(1'b1, 25'h0000123, 8'hA5);
        check("w1_level_after_push", level, 1);
        check("w1_wr_en_not_yet", ctl_wr_enable, 0);
        step();
        check("w1_wr_en", ctl_wr_enable, 1);
        check("w1_rd_en", ctl_rd_enable, 0);
        check("w1_addr",  ctl_wr_addr, 25'h0000123);
        check("w1_data",  ctl_wr_data, 8'hA5);
        check("w1_level_popped", level, 0);
        wait_ack("w1_ack_timeout");
        check("w1_wr_en_held", ctl_wr_enable, 1);
        check("w1_addr_held",  ctl_wr_addr, 25'h0000123);
        step();
        check("w1_wr_en_cleared", ctl_wr_enable, 0);
        repeat (5) step();
        check("w1_no_rsp", rsp_cnt, base);

        // Write then read the same address
        ack_stall = 1;
        rd_lat    = 3;
        base = rsp_cnt;
        push(1'b1, 25'h0001000, 8'h5A);
        push(1'b0, 25'h0001000, 8'h00);
        wait_rsp("wr_rd_rsp_timeout", base + 1);
        check("wr_rd_rsp_valid", rsp_valid, 1);
        check("wr_rd_rsp_data", rsp_data, 8'h5A);
        check("wr_rd_rd_after_wr_ack", 32'(rd_issue_cyc > wr_ack_cyc), 1);
        step();
        check("wr_rd_pulse_width", rsp_valid, 0);
        repeat (5) step();
        check("wr_rd_single_rsp", rsp_cnt, base + 1);
        check("wr_rd_data_hold", rsp_data, 8'h5A);

        // Stray ack / read-data pulses while idle
        base = rsp_cnt;
        force_ack = 1'b1;
        force_rd  = 1'b1;
        step();
        force_ack = 1'b0;
        force_rd  = 1'b0;
        repeat (2) step();
        check("stray_no_rsp", rsp_cnt, base);
        check("stray_wr_en", ctl_wr_enable, 0);
        check("stray_rd_en", ctl_rd_enable, 0);
        check("stray_level", level, 0);
        check("stray_rsp_hold", rsp_data, 8'h5A);

        // Full FIFO with stalled ack, then push/pop interplay
        ack_stall = 10;
        base = wr_issue_cnt;
        push(1'b1, 25'h200, 8'h01);
        step();
        check("full_first_issued", ctl_wr_enable, 1);
        push(1'b1, 25'h201, 8'h02);
        push(1'b1, 25'h202, 8'h03);
        push(1'b1, 25'h203, 8'h04);
        push(1'b1, 25'h204, 8'h05);
        check("full_level4", level, 4);
        check("full_not_ready", req_ready, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 25'h2FF;
        req_wdata = 8'h06;
        repeat (2) step();
        check("full_5th_rejected", level, 4);
        wait_ack("full_ack1_timeout");
        step();
        check("full_idle_level4", level, 4);
        check("full_idle_not_ready", req_ready, 0);
        step();
        check("full_pop_push_blocked", level, 3);
        check("full_ready_again", req_ready, 1);
        check("full_next_issued", ctl_wr_enable, 1);
        step();
        check("full_push_refill", level, 4);
        req_valid = 1'b0;
        wait_ack("full_ack2_timeout");
        step();
        check("full_idle2_level4", level, 4);
        step();
        check("full_pop_level3", level, 3);
        wait_ack("full_ack3_timeout");
        step();
        check("lvl3_idle_level", level, 3);
        check("lvl3_idle_wr_en", ctl_wr_enable, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 25'h2AA;
        req_wdata = 8'h07;
        step();
        req_valid = 1'b0;
        check("lvl3_push_pop_level", level, 3);
        check("lvl3_push_pop_issue", ctl_wr_enable, 1);
        budget = 400;
        while (!(level == 0 && !ctl_wr_enable && !ctl_rd_enable) && budget > 0) begin
            step();
            budget--;
        end
        check("drain_level0", level, 0);
        check("drain_wr_count", wr_issue_cnt - base, 7);

        // Three back-to-back reads, in-order responses
        ack_stall = 0;
        rd_lat    = 2;
        base = rsp_cnt;
        push(1'b0, 25'h10, 8'h00);
        push(1'b0, 25'h20, 8'h00);
        push(1'b0, 25'h30, 8'h00);
        wait_rsp("rd3_rsp_timeout", base + 3);
        check("rd3_rsp0", rsp_log[base],     8'h11);
        check("rd3_rsp1", rsp_log[base + 1], 8'h22);
        check("rd3_rsp2", rsp_log[base + 2], 8'h33);
        check("rd3_one_outstanding", order_err, 0);

        // Reset while waiting for read data
        rd_lat = 40;
        base = rsp_cnt;
        push(1'b0, 25'h20, 8'h00);
        wait_ack("rstrd_ack_timeout");
        step();
        push(1'b1, 25'h300, 8'h08);
        push(1'b1, 25'h301, 8'h09);
        check("rstrd_queued", level, 2);
        rst_n = 1'b0;
        step();
        force_rd = 1'b1;
        step();
        force_rd = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rstrd_ready", req_ready, 1);
        check("rstrd_level", level, 0);
        force_rd = 1'b1;
        step();
        force_rd = 1'b0;
        repeat (5) step();
        check("rstrd_no_rsp", rsp_cnt, base);
        check("rstrd_level_after", level, 0);
        check("rstrd_wr_en", ctl_wr_enable, 0);
        check("rstrd_rd_en", ctl_rd_enable, 0);
        check("rstrd_rsp_data", rsp_data, 0);

        // Whole-run invariants
        check("never_both_enables", both_err, 0);
        check("never_two_reads", order_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
